// File: rtl/uart_mmio_pkg.sv
// ---------------------------------------------------------------------------
// uart_mmio_pkg
// Shared definitions for the memory-mapped UART controller: register
// offsets inside the 16-byte I/O window, STATUS and CTRL bit positions,
// and a saturating helper for the 4-bit RX count field in STATUS.
// ---------------------------------------------------------------------------
package uart_mmio_pkg;

    // Register offsets (addr[3:0]) inside the I/O window
    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    // STATUS bit positions
    localparam int STS_TX_NOT_FULL  = 0;
    localparam int STS_RX_NOT_EMPTY = 1;
    localparam int STS_RX_OVERFLOW  = 2;
    localparam int STS_TX_DROP      = 3;
    localparam int STS_RX_CNT_LSB   = 4;

    // CTRL bit positions (write 1 to clear the matching sticky flag)
    localparam int CTRL_CLR_OVF  = 0;
    localparam int CTRL_CLR_DROP = 1;

    // Clamp an occupancy count into the 4-bit STATUS field
    function automatic logic [3:0] sat_count4(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a first-word fall-through head.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full unless a pop
//                lands in the same cycle)
//   pop        : read request (ignored when empty)
//   dout       : current head; reads as 0 while the FIFO is empty
//   empty/full : occupancy flags
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

    // A pop on an empty FIFO is void; a push on a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Masking the head when empty keeps the output at 0 after reset
    // without having to clear the storage array.
    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is
    // tracked by the pointers/count, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// ---------------------------------------------------------------------------
// uart_mmio_fifo
// Memory-mapped UART controller on the CPU data-memory port. Decodes a
// 16-byte window at BASE_ADDR, buffers TX and RX bytes in two FIFOs and
// keeps two sticky error flags.
//   clk, rst              : CPU clock, synchronous active-high reset
//   stall                 : memory stall; accesses have no effect while high
//   addr, we, re, din     : CPU data-port request
//   dout                  : registered read data
//   uart_data_in[_valid]  : TX byte stream to the UART, uart_data_in_ready accepts
//   uart_data_out[_valid] : RX byte stream from the UART, uart_data_out_ready accepts
// Register map: 0x0 STATUS (R), 0x4 RXDATA (R, pops), 0x8 TXDATA (W),
// 0xC CTRL (W, bit0 clears rx_overflow, bit1 clears tx_drop).
// ---------------------------------------------------------------------------
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [7:0]  uart_data_in,
    output logic        uart_data_in_valid,
    input  logic        uart_data_in_ready,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_data_out_valid,
    output logic        uart_data_out_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    off;
    logic          hit, rd_fire, wr_fire;
    logic          tx_push, tx_pop, tx_empty, tx_full;
    logic          rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]    rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic          ctrl_wr, ovf_set, drop_set;
    logic          ovf_q, ovf_d, drop_q, drop_d, rdy_q;
    logic [31:0]   status, dout_q, dout_d;
    logic          unused_bits;

    // Access decode
    assign off     = addr[3:0];
    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign rd_fire = hit & ~stall & re;
    assign wr_fire = hit & ~stall & (|we);

    assign tx_push = wr_fire & (off == OFF_TXDATA) & we[0];
    assign tx_pop  = uart_data_in_valid & uart_data_in_ready;
    assign rx_pop  = rd_fire & (off == OFF_RXDATA);
    assign rx_push = uart_data_out_valid & uart_data_out_ready;
    assign ctrl_wr = wr_fire & (off == OFF_CTRL) & we[0];

    // A full FIFO is not empty, so a requested pop is always a real pop here
    assign ovf_set  = rx_push & rx_full & ~rx_pop;
    assign drop_set = tx_push & tx_full & ~tx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (din[7:0]),
        .pop   (tx_pop),
        .dout  (uart_data_in),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (uart_data_out),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    assign uart_data_in_valid  = ~tx_empty;
    assign uart_data_out_ready = rdy_q;
    assign dout                = dout_q;

    // STATUS is built from pre-edge state, before this cycle's push/pop
    always_comb begin
        status                                  = '0;
        status[STS_TX_NOT_FULL]                 = ~tx_full;
        status[STS_RX_NOT_EMPTY]                = ~rx_empty;
        status[STS_RX_OVERFLOW]                 = ovf_q;
        status[STS_TX_DROP]                     = drop_q;
        status[STS_RX_CNT_LSB+3:STS_RX_CNT_LSB] = sat_count4(32'(rx_count));
    end

    // Sticky flags: a same-cycle set overrides the clear
    always_comb begin
        ovf_d  = (ovf_q  & ~(ctrl_wr & din[CTRL_CLR_OVF]))  | ovf_set;
        drop_d = (drop_q & ~(ctrl_wr & din[CTRL_CLR_DROP])) | drop_set;
    end

    // Read data only changes on a firing read; everything else holds
    always_comb begin
        dout_d = dout_q;
        if (rd_fire) begin
            case (off)
                OFF_STATUS: dout_d = status;
                OFF_RXDATA: dout_d = {24'b0, rx_head};
                default:    dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
            dout_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            dout_q <= dout_d;
            rdy_q  <= 1'b1;
        end
    end

    // Inputs and counts that the register map never looks at
    assign unused_bits = ^{din[31:8], we[3:1], tx_count};

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_fifo
// Queue-based reference model of the UART MMIO block, compared against the
// DUT on every falling edge, plus directed scenarios with literal values.
// ---------------------------------------------------------------------------
module tb_uart_mmio_fifo;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [7:0]  uart_data_in;
    logic        uart_data_in_valid;
    logic        uart_data_in_ready = 1'b0;
    logic [7:0]  uart_data_out = '0;
    logic        uart_data_out_valid = 1'b0;
    logic        uart_data_out_ready;

    uart_mmio_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .addr                (addr),
        .we                  (we),
        .re                  (re),
        .din                 (din),
        .dout                (dout),
        .uart_data_in        (uart_data_in),
        .uart_data_in_valid  (uart_data_in_valid),
        .uart_data_in_ready  (uart_data_in_ready),
        .uart_data_out       (uart_data_out),
        .uart_data_out_valid (uart_data_out_valid),
        .uart_data_out_ready (uart_data_out_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  tx_m[$];
    logic [7:0]  rx_m[$];
    bit          ovf_m, drop_m, rdy_m;
    logic [31:0] dout_m;

    function automatic logic [31:0] status_m();
        int n;
        n = (rx_m.size() > 15) ? 15 : rx_m.size();
        return {24'b0, 4'(n), drop_m, ovf_m, (rx_m.size() != 0), (tx_m.size() < DEPTH)};
    endfunction

    always @(posedge clk) begin : model
        bit         hit, rd, wr, tx_pop, tx_push, rx_pop, rx_push, clr;
        logic [3:0] o;
        if (rst) begin
            tx_m.delete();
            rx_m.delete();
            ovf_m  = 0;
            drop_m = 0;
            rdy_m  = 0;
            dout_m = '0;
        end else begin
            o   = addr[3:0];
            hit = (addr[31:4] == BASE[31:4]) && !stall;
            rd  = hit && re;
            wr  = hit && (we != 0);
            if (rd) begin
                if (o == 4'h0)      dout_m = status_m();
                else if (o == 4'h4) dout_m = (rx_m.size() != 0) ? {24'b0, rx_m[0]} : 32'h0;
                else                dout_m = 32'h0;
            end
            tx_pop  = (tx_m.size() != 0) && uart_data_in_ready;
            tx_push = wr && (o == 4'h8) && we[0];
            rx_pop  = rd && (o == 4'h4) && (rx_m.size() != 0);
            rx_push = uart_data_out_valid && rdy_m;
            clr     = wr && (o == 4'hC) && we[0];
            if (clr && din[0]) ovf_m  = 0;
            if (clr && din[1]) drop_m = 0;
            // pop first, then the push lands if there is room
            if (tx_pop) void'(tx_m.pop_front());
            if (tx_push) begin
                if (tx_m.size() < DEPTH) tx_m.push_back(din[7:0]);
                else drop_m = 1;
            end
            if (rx_pop) void'(rx_m.pop_front());
            if (rx_push) begin
                if (rx_m.size() < DEPTH) rx_m.push_back(uart_data_out);
                else ovf_m = 1;
            end
            rdy_m = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("dout", dout, dout_m);
        check("tx_valid", {31'b0, uart_data_in_valid}, {31'b0, tx_m.size() != 0});
        check("tx_data", {24'b0, uart_data_in}, (tx_m.size() != 0) ? {24'b0, tx_m[0]} : 32'h0);
        check("rx_ready", {31'b0, uart_data_out_ready}, {31'b0, rdy_m});
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        addr = '0; we = '0; re = 1'b0; din = '0; stall = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] o, output logic [31:0] val);
        @(negedge clk);
        addr = BASE | 32'(o); re = 1'b1; we = '0;
        @(negedge clk);
        idle_bus();
        val = dout;
    endtask

    task automatic wr_reg(input logic [3:0] o, input logic [31:0] d);
        @(negedge clk);
        addr = BASE | 32'(o); we = 4'hF; re = 1'b0; din = d;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic uart_rx(input logic [7:0] b);
        @(negedge clk);
        uart_data_out_valid = 1'b1; uart_data_out = b;
        @(negedge clk);
        uart_data_out_valid = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        rd_reg(4'h0, v);
        check("reset_status", v, 32'h0000_0001);

        // Three stores with the transmitter not ready, then drain
        wr_reg(4'h8, 32'h41);
        check("tx_valid_after_store", {31'b0, uart_data_in_valid}, 32'h1);
        check("tx_head_first", {24'b0, uart_data_in}, 32'h41);
        wr_reg(4'h8, 32'h42);
        wr_reg(4'h8, 32'h43);
        uart_data_in_ready = 1'b1;
        #1 check("drain0", {23'b0, uart_data_in_valid, uart_data_in}, 32'h141);
        @(negedge clk); #1 check("drain1", {23'b0, uart_data_in_valid, uart_data_in}, 32'h142);
        @(negedge clk); #1 check("drain2", {23'b0, uart_data_in_valid, uart_data_in}, 32'h143);
        @(negedge clk); #1 check("drain_done", {31'b0, uart_data_in_valid}, 32'h0);
        uart_data_in_ready = 1'b0;

        // Nine stores into an eight-entry FIFO
        for (int i = 0; i < 9; i++) wr_reg(4'h8, 32'h50 + 32'(i));
        rd_reg(4'h0, v);
        check("tx_full_drop_status", v, 32'h0000_0008);
        wr_reg(4'hC, 32'h2);
        rd_reg(4'h0, v);
        check("tx_drop_cleared", v, 32'h0000_0000);

        // Two received bytes, TX still full
        uart_rx(8'h7A);
        uart_rx(8'h80);
        rd_reg(4'h0, v);
        check("rx_two_status", v, 32'h0000_0022);
        @(negedge clk); uart_data_in_ready = 1'b1;
        repeat (10) @(negedge clk);
        uart_data_in_ready = 1'b0;
        rd_reg(4'h4, v); check("rx_pop_7a", v, 32'h7A);
        rd_reg(4'h4, v); check("rx_pop_80", v, 32'h80);
        rd_reg(4'h4, v); check("rx_pop_empty", v, 32'h0);
        rd_reg(4'h0, v); check("rx_empty_status", v, 32'h0000_0001);

        // RX overflow, then simultaneous push/pop at full
        for (int i = 0; i < 8; i++) uart_rx(8'h10 + 8'(i));
        uart_rx(8'h99);
        rd_reg(4'h0, v); check("rx_overflow_status", v, 32'h0000_0087);
        wr_reg(4'hC, 32'h1);
        rd_reg(4'h0, v); check("rx_ovf_cleared", v, 32'h0000_0083);
        @(negedge clk);
        addr = BASE | 32'h4; re = 1'b1;
        uart_data_out_valid = 1'b1; uart_data_out = 8'hAB;
        @(negedge clk);
        idle_bus(); uart_data_out_valid = 1'b0;
        check("rx_full_pushpop_head", dout, 32'h10);
        rd_reg(4'h0, v); check("rx_full_pushpop_status", v, 32'h0000_0083);

        // Stall holds a read and a store
        @(negedge clk);
        stall = 1'b1; addr = BASE | 32'h4; re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_read_dout", dout, 32'h0000_0083);
        end
        stall = 1'b0;
        @(negedge clk);
        idle_bus();
        check("stall_read_released", dout, 32'h11);
        stall = 1'b1; addr = BASE | 32'h8; we = 4'h1; din = 32'hC5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_store_held", {31'b0, uart_data_in_valid}, 32'h0);
        end
        stall = 1'b0;
        @(negedge clk);
        idle_bus();
        check("stall_store_released", {23'b0, uart_data_in_valid, uart_data_in}, 32'h1C5);
        rd_reg(4'h0, v); check("stall_status", v, 32'h0000_0073);

        // Randomized traffic, occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 399) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else if ($urandom_range(0, 15) == 0) addr = BASE | 32'($urandom_range(0, 15));
            else addr = BASE | {28'b0, 2'($urandom_range(0, 3)), 2'b00};
            re  = $urandom_range(0, 1) == 1;
            we  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            din = $urandom;
            uart_data_in_ready  = ($urandom_range(0, 2) == 0);
            uart_data_out_valid = ($urandom_range(0, 1) == 1);
            uart_data_out       = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; idle_bus();
        uart_data_in_ready = 1'b0; uart_data_out_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
